// File: rtl/tug_press_gen.sv
// Two-player tug-of-war press generator: per-key synchronizer + debounce FSM, one-cycle L/R pulses.
// Optional computer player on R is compiled in with `define CPU_PLAYER_EN.

module tug_key_deb #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        key_s;

  assign key_s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = CONFIRM;
          cnt_d   = 16'd1;
        end
      end
      CONFIRM: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 16'(DEBOUNCE_CYCLES)) begin
          // press is accepted on the (DEBOUNCE_CYCLES+1)th consecutive high cycle
          state_d = HELD;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HELD: begin
        if (!key_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

module tug_press_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef CPU_PLAYER_EN
  , parameter int unsigned CPU_TICK_CYCLES = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_l_raw,
  input  logic       key_r_raw,
`ifdef CPU_PLAYER_EN
  input  logic [8:0] cpu_level,
`endif
  output logic       L,
  output logic       R
);
  logic l_press, r_press, cpu_fire;
  logic l_q, l_d, r_q, r_d;

  tug_key_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk(clk), .rst(rst), .key_raw(key_l_raw), .press(l_press)
  );

  tug_key_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk(clk), .rst(rst), .key_raw(key_r_raw), .press(r_press)
  );

`ifdef CPU_PLAYER_EN
  logic [9:0]  lfsr_q, lfsr_d;
  logic [15:0] tick_q, tick_d;
  logic        tick_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 10'h001;
      tick_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      tick_q <= tick_d;
    end
  end

  // x^10 + x^7 + 1 Fibonacci form; a nonzero seed never reaches zero
  always_comb begin
    lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    tick_wrap = (tick_q == 16'(CPU_TICK_CYCLES - 1));
    tick_d    = tick_wrap ? '0 : tick_q + 16'd1;
    cpu_fire  = tick_wrap && (lfsr_q[8:0] < cpu_level);
  end
`else
  assign cpu_fire = 1'b0;
`endif

  always_comb begin
    l_d = l_press;
    r_d = r_press | cpu_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      l_q <= l_d;
      r_q <= r_d;
    end
  end

  assign L = l_q;
  assign R = r_q;
endmodule

// File: tb/tb_tug_press_gen.sv
// Scoreboard bench for tug_press_gen (default build): a run-length press model feeds
// expected {L,R} per cycle into a queue; a negedge monitor pops and compares.
module tb_tug_press_gen;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_l_raw = 1'b0;
  logic key_r_raw = 1'b0;
  logic L, R;

  always #5 clk = ~clk;

  tug_press_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key_l_raw(key_l_raw), .key_r_raw(key_r_raw), .L(L), .R(R)
  );

  logic [1:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  int cnt_l = 0, cnt_r = 0, cnt_lr = 0;

  // Model: a key's press fires when its synchronized level has been high for
  // exactly D+1 consecutive cycles; synchronized level = raw level two edges ago.
  int   run_l = 0, run_r = 0;
  logic pl1 = 0, pl2 = 0, pr1 = 0, pr2 = 0;

  always @(posedge clk) begin : model
    logic el, er;
    if (rst) begin
      pl1 = 0; pl2 = 0; pr1 = 0; pr2 = 0;
      run_l = 0; run_r = 0;
      el = 0; er = 0;
    end else begin
      run_l = pl2 ? run_l + 1 : 0;
      run_r = pr2 ? run_r + 1 : 0;
      el = (run_l == D + 1);
      er = (run_r == D + 1);
      pl2 = pl1; pl1 = key_l_raw;
      pr2 = pr1; pr1 = key_r_raw;
    end
    exp_q.push_back({el, er});
  end

  always @(negedge clk) begin : monitor
    logic [1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if ({L, R} === e) n_pass++;
      else $display("FAIL lr_cycle t=%0t got LR=%b%b expected LR=%b", $time, L, R, e);
      if (L === 1'b1) cnt_l++;
      if (R === 1'b1) cnt_r++;
      if (L === 1'b1 && R === 1'b1) cnt_lr++;
    end
  end

  task automatic drive(input logic l, input logic r, input logic rs, input int n);
    repeat (n) begin
      @(negedge clk);
      key_l_raw = l;
      key_r_raw = r;
      rst       = rs;
    end
  endtask

  task automatic chk(input string name, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, expv);
  endtask

  initial begin
    int l0, r0, lr0;
    int hl, hr;
    logic lv, rv;

    drive(0, 0, 1, 2);
    drive(0, 0, 0, 7);

    // single long hold on L
    l0 = cnt_l; r0 = cnt_r;
    drive(1, 0, 0, 20);
    drive(0, 0, 0, 8);
    @(posedge clk);
    chk("l_hold_one_pulse", cnt_l - l0, 1);
    chk("r_quiet_during_l", cnt_r - r0, 0);

    // short R bursts never qualify
    r0 = cnt_r;
    drive(0, 1, 0, 3);
    drive(0, 0, 0, 2);
    drive(0, 1, 0, 3);
    drive(0, 0, 0, 10);
    @(posedge clk);
    chk("r_glitch_no_pulse", cnt_r - r0, 0);

    // simultaneous presses coincide
    l0 = cnt_l; r0 = cnt_r; lr0 = cnt_lr;
    drive(1, 1, 0, 10);
    drive(0, 0, 0, 8);
    @(posedge clk);
    chk("both_coincident", cnt_lr - lr0, 1);
    chk("both_l_count", cnt_l - l0, 1);
    chk("both_r_count", cnt_r - r0, 1);

    // reset during CONFIRM discards, held key re-qualifies
    l0 = cnt_l;
    drive(1, 0, 0, 4);
    drive(1, 0, 1, 1);
    drive(1, 0, 0, 12);
    drive(0, 0, 0, 8);
    @(posedge clk);
    chk("reset_mid_confirm", cnt_l - l0, 1);

    // reset on the pulse edge kills the pulse
    l0 = cnt_l;
    drive(1, 0, 0, 6);
    drive(1, 0, 1, 1);
    drive(0, 0, 0, 8);
    @(posedge clk);
    chk("reset_on_pulse", cnt_l - l0, 0);

    // long hold with release bounce
    l0 = cnt_l;
    drive(1, 0, 0, 200);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 2);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 10);
    @(posedge clk);
    chk("long_hold_bounce", cnt_l - l0, 1);

    // randomized bursty stimulus with occasional reset
    hl = 1; hr = 1; lv = 0; rv = 0;
    for (int i = 0; i < 3000; i++) begin
      hl--; hr--;
      if (hl <= 0) begin lv = ~lv; hl = $urandom_range(1, 2 * D + 2); end
      if (hr <= 0) begin rv = ~rv; hr = $urandom_range(1, 2 * D + 2); end
      drive(lv, rv, ($urandom_range(0, 199) == 0), 1);
    end
    drive(0, 0, 0, 10);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("some_l_pulses", (cnt_l > 10) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
